// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA result-register stream datapath.
//   stream_state_t : FSM encoding of the word serializer
//   calc_nwords    : words per streamed result; returns 0 for an illegal
//                    WIDTH/WORD pairing so callers can reject it at elaboration
package rsa_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } stream_state_t;

  function automatic int calc_nwords(input int width, input int word);
    if (word < 1) begin
      return 0;
    end else if ((width % word) != 0) begin
      return 0;
    end else begin
      return width / word;
    end
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Word serializer: snapshots a WIDTH-bit value and emits it as NWORDS words
// of WORD bits, least-significant word first, over a valid/ready handshake.
// Ports:
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   ena_i           : global enable; 0 freezes state and drops valid
//   clear_n_i       : active-low clear; aborts an active stream
//   start_i         : request a snapshot of snap_i (accepted only in IDLE)
//   snap_i          : value captured on an accepted start
//   ready_i         : sink ready
//   valid_o, data_o, last_o : stream word, valid and final-word marker
//   busy_o          : high for the whole stream
module word_serializer
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic             clear_n_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] snap_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WORD-1:0]  data_o,
  output logic             last_o,
  output logic             busy_o
);

  localparam int NWORDS = calc_nwords(WIDTH, WORD);
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  if (WORD < 1) begin : g_bad_word
    $error("word_serializer: WORD must be >= 1");
  end
  if (NWORDS < 1) begin : g_bad_width
    $error("word_serializer: WIDTH must be a non-zero multiple of WORD");
  end

  stream_state_t    state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CW-1:0]    count_q, count_d;

  // State, shadow and word-count registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      shadow_q <= {WIDTH{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Next-state logic: snapshot on start, advance on transfer, abort on clear
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    if (ena_i) begin
      case (state_q)
        ST_IDLE: begin
          // a start coinciding with clear is dropped
          if (start_i && clear_n_i) begin
            state_d  = ST_STREAM;
            shadow_d = snap_i;
            count_d  = {CW{1'b0}};
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_STREAM: begin
          // abort outranks a same-cycle transfer
          if (!clear_n_i) begin
            state_d  = ST_IDLE;
            shadow_d = {WIDTH{1'b0}};
            count_d  = {CW{1'b0}};
          end else if (ready_i) begin
            if (count_q == LAST_IDX) begin
              state_d  = ST_IDLE;
              shadow_d = {WIDTH{1'b0}};
              count_d  = {CW{1'b0}};
            end else begin
              shadow_d = shadow_q >> WORD;
              count_d  = count_q + CW'(1);
            end
          end else begin
            state_d  = ST_STREAM;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          shadow_d = {WIDTH{1'b0}};
          count_d  = {CW{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Output decode: depends only on state and ena, never on ready
  always_comb begin
    valid_o = 1'b0;
    data_o  = {WORD{1'b0}};
    last_o  = 1'b0;
    busy_o  = 1'b0;
    if (state_q == ST_STREAM) begin
      valid_o = ena_i;
      data_o  = shadow_q[WORD-1:0];
      last_o  = (count_q == LAST_IDX);
      busy_o  = 1'b1;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/result_reg_stream.sv
// Montgomery-loop result register with snapshot-and-stream unload.
// Holds R_i (clear / load from A or reg_rji / divide-by-2 shift) and hands a
// pre-update snapshot of R_i to a word serializer on start_out. R_i keeps
// updating while an earlier result is still being drained.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ena                 : global enable
//   clear               : active-low clear of R_i; aborts an active stream
//   load, lock          : load R_i from reg_rji (lock=1) or A (lock=0)
//   shift               : R_i >> 1 with zero fill
//   reg_rji, A          : load sources
//   start_out           : snapshot and stream current R_i
//   out_ready           : sink ready
//   R_i                 : result register
//   out_valid/out_data/out_last/busy : stream interface
module result_reg_stream
  import rsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             clear,
  input  logic             load,
  input  logic             lock,
  input  logic             shift,
  input  logic [WIDTH-1:0] reg_rji,
  input  logic [WIDTH-1:0] A,
  input  logic             start_out,
  input  logic             out_ready,
  output logic [WIDTH-1:0] R_i,
  output logic             out_valid,
  output logic [WORD-1:0]  out_data,
  output logic             out_last,
  output logic             busy
);

  logic [WIDTH-1:0] r_q, r_d;

  // Result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= {WIDTH{1'b0}};
    end else begin
      r_q <= r_d;
    end
  end

  // R_i update: clear > load > shift > hold
  always_comb begin
    r_d = r_q;
    if (ena) begin
      if (!clear) begin
        r_d = {WIDTH{1'b0}};
      end else if (load) begin
        r_d = lock ? reg_rji : A;
      end else if (shift) begin
        r_d = r_q >> 1;
      end else begin
        r_d = r_q;
      end
    end else begin
      r_d = r_q;
    end
  end

  assign R_i = r_q;

  // snapshot is the registered R_i, so a same-cycle load/shift is not captured
  word_serializer #(
    .WIDTH (WIDTH),
    .WORD  (WORD)
  ) u_ser (
    .clk_i     (clk),
    .rst_i     (rst),
    .ena_i     (ena),
    .clear_n_i (clear),
    .start_i   (start_out),
    .snap_i    (r_q),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .last_o    (out_last),
    .busy_o    (busy)
  );

endmodule

// File: tb/tb_result_reg_stream.sv
module tb_result_reg_stream;

  localparam int WIDTH  = 8;
  localparam int WORD   = 4;
  localparam int NWORDS = WIDTH / WORD;

  logic             clk = 1'b0;
  logic             rst, ena, clear, load, lock, shift, start_out, out_ready;
  logic [WIDTH-1:0] reg_rji, A, R_i;
  logic             out_valid, out_last, busy;
  logic [WORD-1:0]  out_data;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [WORD-1:0] data;
    logic            last;
  } word_t;
  word_t sb_q[$];

  typedef struct packed {
    logic             ena;
    logic             clear;
    logic             load;
    logic             lock;
    logic             shift;
    logic [WIDTH-1:0] rji;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] exp_r;
  } vec_t;
  vec_t vecs[11];

  result_reg_stream #(.WIDTH(WIDTH), .WORD(WORD)) dut (
    .clk(clk), .rst(rst), .ena(ena), .clear(clear), .load(load), .lock(lock),
    .shift(shift), .reg_rji(reg_rji), .A(A), .start_out(start_out),
    .out_ready(out_ready), .R_i(R_i), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [WIDTH-1:0] snap);
    word_t w;
    for (int i = 0; i < NWORDS; i++) begin
      w.data = snap[i*WORD +: WORD];
      w.last = (i == NWORDS - 1);
      sb_q.push_back(w);
    end
  endtask

  // Scoreboard: every handshake seen mid-cycle will transfer on the next edge
  always @(negedge clk) begin
    word_t exp_w;
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_extra: got word %0h last %0b expected no word", out_data, out_last);
      end else begin
        exp_w = sb_q.pop_front();
        if (out_data !== exp_w.data || out_last !== exp_w.last) begin
          tests_failed++;
          $display("FAIL sb_word: got %0h/%0b expected %0h/%0b",
                   out_data, out_last, exp_w.data, exp_w.last);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; ena = 1'b1; clear = 1'b1; load = 1'b0; lock = 1'b0; shift = 1'b0;
    reg_rji = 8'h00; A = 8'h00; start_out = 1'b0; out_ready = 1'b0;

    //                ena   clr   load  lock  shift rji    a      exp
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hA5, 8'hA5};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 8'h00, 8'h3C};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h77, 8'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h0F, 8'h0F};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h07};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h03};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h03};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h03};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h81, 8'h00, 8'h81};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h40};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_r", R_i, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_valid", out_valid, 1'b0);

    // asynchronous reset mid-cycle
    load = 1'b1; A = 8'h5A;
    tick();
    load = 1'b0;
    check("load_pre_rst", R_i, 8'h5A);
    #2 rst = 1'b1;
    #1;
    check("async_rst_r", R_i, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;

    // table: R_i update priority, shift and enable freeze
    for (int i = 0; i < 11; i++) begin
      ena = vecs[i].ena; clear = vecs[i].clear; load = vecs[i].load;
      lock = vecs[i].lock; shift = vecs[i].shift; reg_rji = vecs[i].rji; A = vecs[i].a;
      tick();
      check($sformatf("vec%0d_r", i), R_i, vecs[i].exp_r);
    end
    ena = 1'b1; clear = 1'b1; load = 1'b0; lock = 1'b0; shift = 1'b0;

    // basic stream of A5
    load = 1'b1; A = 8'hA5;
    tick();
    load = 1'b0;
    check("t3_r", R_i, 8'hA5);
    start_out = 1'b1; out_ready = 1'b1; push_words(8'hA5);
    tick();
    start_out = 1'b0;
    check("t3_valid0", out_valid, 1'b1);
    check("t3_data0", out_data, 4'h5);
    check("t3_last0", out_last, 1'b0);
    check("t3_busy0", busy, 1'b1);
    tick();
    check("t3_data1", out_data, 4'hA);
    check("t3_last1", out_last, 1'b1);
    tick();
    check("t3_valid_end", out_valid, 1'b0);
    check("t3_busy_end", busy, 1'b0);
    check("t3_data_idle", out_data, 4'h0);

    // backpressure and enable freeze
    start_out = 1'b1; out_ready = 1'b0; push_words(8'hA5);
    tick();
    start_out = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t4_bp_data%0d", k), out_data, 4'h5);
      check($sformatf("t4_bp_last%0d", k), out_last, 1'b0);
      check($sformatf("t4_bp_valid%0d", k), out_valid, 1'b1);
      tick();
    end
    ena = 1'b0; load = 1'b1; A = 8'h33;
    #1;
    check("t4_ena0_valid", out_valid, 1'b0);
    tick();
    check("t4_ena0_r1", R_i, 8'hA5);
    tick();
    check("t4_ena0_r2", R_i, 8'hA5);
    check("t4_ena0_busy", busy, 1'b1);
    ena = 1'b1; load = 1'b0; out_ready = 1'b1;
    #1;
    check("t4_resume_data0", out_data, 4'h5);
    tick();
    check("t4_resume_data1", out_data, 4'hA);
    check("t4_resume_last1", out_last, 1'b1);
    tick();
    check("t4_done", busy, 1'b0);

    // snapshot ignores same-cycle load; mid-stream start ignored
    start_out = 1'b1; load = 1'b1; A = 8'hFF; push_words(8'hA5);
    tick();
    start_out = 1'b0; load = 1'b0;
    check("t5_r", R_i, 8'hFF);
    check("t5_data0", out_data, 4'h5);
    start_out = 1'b1;
    tick();
    start_out = 1'b0;
    check("t5_data1", out_data, 4'hA);
    check("t5_last1", out_last, 1'b1);
    tick();
    check("t5_valid_end", out_valid, 1'b0);
    repeat (3) tick();
    check("t5_no_extra", busy, 1'b0);

    // abort by clear after the first word
    start_out = 1'b1; push_words(8'hFF);
    tick();
    start_out = 1'b0;
    check("t6_data0", out_data, 4'hF);
    tick();
    check("t6_last1", out_last, 1'b1);
    clear = 1'b0; out_ready = 1'b0;
    tick();
    clear = 1'b1;
    check("t6_abort_valid", out_valid, 1'b0);
    check("t6_abort_busy", busy, 1'b0);
    check("t6_abort_r", R_i, 8'h00);
    sb_q.delete();

    // reset during a stream
    load = 1'b1; A = 8'hC3;
    tick();
    load = 1'b0;
    start_out = 1'b1; push_words(8'hC3);
    tick();
    start_out = 1'b0;
    check("t6_rst_busy_pre", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    sb_q.delete();
    tick();
    rst = 1'b0;

    // clean stream after reset
    load = 1'b1; A = 8'h96;
    tick();
    load = 1'b0;
    start_out = 1'b1; out_ready = 1'b1; push_words(8'h96);
    tick();
    start_out = 1'b0;
    check("t6_new_data0", out_data, 4'h6);
    check("t6_new_last0", out_last, 1'b0);
    tick();
    check("t6_new_data1", out_data, 4'h9);
    check("t6_new_last1", out_last, 1'b1);
    tick();
    check("t6_new_end", out_valid, 1'b0);
    repeat (2) tick();
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/result_reg_stream.md
Name: result_reg_stream

Overview:
Parametrised successor to the Montgomery-loop result register for the RSA datapath. It holds the WIDTH-bit partial result R_i, supports clear, load (from A or the locked reg_rji value) and a new divide-by-2 shift mode. It also adds a snapshot-and-stream unload path that emits the captured result word-serially over a valid/ready handshake. The core can start the next iteration while a previous result is still being drained.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of WORD
WORD, 4, stream word width in bits
NWORDS, WIDTH/WORD, derived localparam, words per streamed result; must be >= 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
ena  input  1  global enable; 0 freezes all state
clear  input  1  synchronous active-low clear of R_i; also aborts an active stream
load  input  1  load R_i
lock  input  1  load source select: 1 = reg_rji, 0 = A
shift  input  1  R_i <= R_i >> 1, zero fill at MSB
reg_rji  input  WIDTH  locked load source
A  input  WIDTH  unlocked load source
start_out  input  1  request snapshot and stream of current R_i
out_ready  input  1  sink ready
R_i  output  WIDTH  result register
out_valid  output  1  stream word valid
out_data  output  WORD  stream word, least-significant word first
out_last  output  1  marks final word of a result
busy  output  1  stream in progress

Behaviour:
- rst=1, asynchronous: R_i=0, shadow=0, word count=0, state IDLE. Resulting outputs: out_valid=0, out_data=0, out_last=0, busy=0.
- ena=0: no register updates. out_valid is forced to 0, so no transfer occurs. State and count hold.
- R_i update when ena=1, priority order:
  - clear=0 -> 0
  - else load -> (lock ? reg_rji : A)
  - else shift -> {1'b0, R_i[WIDTH-1:1]}
  - else hold
- R_i updates are independent of stream state.
- FSM states: IDLE, STREAM.
- IDLE -> STREAM when ena=1, start_out=1 and clear=1:
  - shadow <= the pre-update value of R_i, so a same-cycle load/shift does not affect the snapshot.
  - count <= 0.
  - start_out while clear=0 is ignored.
- STREAM outputs:
  - out_valid = ena; out_data = shadow[WORD-1:0]; out_last = (count == NWORDS-1).
  - busy = 1 throughout STREAM.
- Transfer = out_valid & out_ready. On each transfer: shadow >>= WORD, count++.
- On the transfer where out_last=1: next state is IDLE and shadow is zeroed.
- Without out_ready, out_data and out_last hold stable (backpressure).
- start_out in STREAM is ignored; there is no queueing.
- clear=0 in STREAM (ena=1) aborts: next state IDLE, shadow=0, count=0, R_i=0. Any same-cycle transfer is still seen by the sink, but the abort wins.
- In IDLE: out_data=0, out_last=0.
- Latency: the first word is valid the cycle after start_out is accepted. With out_ready held high, the minimum stream length is NWORDS cycles.
- Outputs are registered state or simple decodes of state and ena. There is no combinational path from out_ready to out_valid.
- Elaboration-time assertions: WIDTH % WORD == 0, WORD >= 1.

Decomposition:
- Shared package rsa_pkg:
  - typedef enum logic {ST_IDLE, ST_STREAM} stream_state_t
  - a width-checking helper function for NWORDS
- One natural sub-module: word_serializer.
  - Owns the shadow register, count, FSM and handshake, parametrised by WIDTH/WORD.
  - The top keeps the R_i update logic and snapshot wiring.

Test Plan:
WIDTH=8, WORD=4, ena=1 unless stated.
1. Assert rst mid-cycle -> R_i=00, busy=0 immediately. Then load=1, lock=0, A=A5 -> R_i=A5; next cycle load=1, lock=1, reg_rji=3C -> R_i=3C.
2. Priority: clear=0, load=1, shift=1 -> R_i=00. Then load=1, shift=1, A=0F -> R_i=0F. Then shift=1 only -> R_i=07, then 03.
3. R_i=A5, pulse start_out, out_ready=1 -> cycle+1: out_valid=1, data=5, last=0; cycle+2: data=A, last=1; cycle+3: out_valid=0, busy=0.
4. Backpressure and enable: out_ready=0 for 3 cycles -> data stays 5, last=0. Then ena=0 for 2 cycles -> out_valid=0 and R_i frozen despite load=1. Resume -> 5, A.
5. R_i=A5, start_out with load=1, A=FF in the same cycle -> R_i=FF, stream emits 5 then A. A second start_out mid-stream is ignored (exactly 2 words).
6. Abort: clear=0 after the first word -> next cycle out_valid=0, busy=0, R_i=00. rst during STREAM -> out_valid=0 asynchronously. A new start_out then streams cleanly.
